// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs {acc, op, imm} field sets into instruction bytes, buffers
//            them in a FIFO and writes them to sequential program-memory
//            addresses. Optional running checksum: INSTR_ENCODER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_using_acc,
    input  logic [2:0]            in_opcode,
    input  logic [3:0]            in_immediate,
    input  logic                  in_last,
    input  logic                  clear,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ready,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    output logic [7:0]            checksum
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [c_ptr_w:0]    c_occ_full = (c_ptr_w+1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]    c_occ_one  = (c_ptr_w+1)'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one  = c_ptr_w'(1);
    localparam logic [ADDR_WIDTH:0] c_capacity = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_cnt_one  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [8:0]            r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_occ;
    logic                  r_last_accepted;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;
    logic [ADDR_WIDTH:0]   r_count;

    logic [7:0]            w_in_byte;
    logic [8:0]            w_in_entry;
    logic [8:0]            w_head;
    logic [c_ptr_w-1:0]    w_rd_ptr_nxt;
    logic [7:0]            w_next_byte;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_has_next;
    logic                  w_load_head;
    logic                  w_load_next;
    logic [ADDR_WIDTH:0]   w_count_inc;

    assign w_in_byte    = {in_is_using_acc, in_opcode, in_immediate};
    assign w_in_entry   = {in_last, w_in_byte};
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
    assign w_full       = (r_occ == c_occ_full);
    assign w_count_inc  = r_count + c_cnt_one;

    // rst_n gates in_ready so the port reads 0 for the whole reset window.
    assign in_ready = rst_n && !w_full && (r_state != c_st_done) && !r_last_accepted && !clear;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == c_st_write) && mem_ready && !clear;

    // After a pop the next head is either the second stored entry or, when the
    // FIFO held only the head, the byte being pushed in the same cycle.
    assign w_has_next  = (r_occ > c_occ_one) || w_push;
    assign w_next_byte = (r_occ > c_occ_one) ? r_fifo[w_rd_ptr_nxt][7:0] : w_in_byte;
    assign w_load_head = (r_state == c_st_idle) && (r_occ != '0);
    assign w_load_next = w_pop && w_has_next;

    assign mem_we    = (r_state == c_st_write);
    assign done      = (r_state == c_st_done);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_occ != '0) w_state_nxt = c_st_write;
            end
            c_st_write: begin
                if (w_pop) begin
                    if (w_head[8] || (w_count_inc == c_capacity)) w_state_nxt = c_st_done;
                    else if (!w_has_next)                         w_state_nxt = c_st_idle;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_done;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (clear) w_state_nxt = c_st_idle;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_occ           <= '0;
            r_last_accepted <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_count         <= '0;
        end else if (clear) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_occ           <= '0;
            r_last_accepted <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_count         <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                if (in_last) r_last_accepted <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= w_rd_ptr_nxt;
                r_mem_addr <= r_mem_addr + c_addr_one;
                r_count    <= w_count_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_occ_one;
                2'b01:   r_occ <= r_occ - c_occ_one;
                default: r_occ <= r_occ;
            endcase
            if (w_load_head)      r_mem_wdata <= w_head[7:0];
            else if (w_load_next) r_mem_wdata <= w_next_byte;
        end
    end

`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 8'h00;
        end else if (clear) begin
            r_checksum <= 8'h00;
        end else if (w_pop) begin
            r_checksum <= r_checksum + r_mem_wdata;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

endmodule
`default_nettype wire
